// File: rtl/riscv_definitions.sv
// Shared RISC-V core definitions: next-PC select, fetch sequencer states and
// default fetch-control parameters.
package riscv_definitions;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    JUMP     = 2'd1,
    TRAP     = 2'd2
  } nextPCType_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchCtrlState_e;

  localparam int BOOT_WAIT_DEF   = 2;
  localparam int MAX_WAIT_DEF    = 15;
  localparam int FLUSH_DEPTH_DEF = 1;

endpackage

// File: rtl/fetch_wait_timer.sv
// Memory wait-state timer: counts consecutive cycles without an ack and flags
// when the count reaches MAX_WAIT. Shared by fetch and load/store control.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic ack_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = ack_i ? 8'd0 : cnt_q + 8'd1;
  end

  // Flags on the miss that makes the count reach MAX_WAIT, so the owner can
  // leave its active state at this same edge.
  assign expired_o = en_i & ~ack_i & (cnt_d == 8'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: fetch enable, next-PC select, IF/ID flush and
// imem request. Optional perf counters under `FETCH_PERF_CNT_EN.
module fetch_control
  import riscv_definitions::*;
#(
  parameter int BOOT_WAIT   = BOOT_WAIT_DEF,
  parameter int MAX_WAIT    = MAX_WAIT_DEF,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic        stall_req_i,
  input  logic        jump_req_i,
  input  logic        trap_req_i,
  output logic        redirect_ack_o,
  output logic        if_en_o,
  output nextPCType_e pc_sel_o,
  output logic        if_flush_o,
  output logic        fetch_timeout_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_redirect_cnt_o
`endif
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);
  localparam logic [1:0] FLUSH_LD  = 2'(FLUSH_DEPTH);

  fetchCtrlState_e state_q, state_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic [1:0]      flush_cnt_q, flush_cnt_d;
  logic            timeout_q, timeout_d;
  logic            tmr_en, tmr_expired, redir;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (tmr_en),
    .ack_i     (imem_ack_i),
    .expired_o (tmr_expired)
  );

  assign redir = (trap_req_i | jump_req_i) & imem_ack_i & (state_q == RUN);

  always_comb begin
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    imem_req_o     = 1'b0;
    if_en_o        = 1'b0;
    redirect_ack_o = 1'b0;
    pc_sel_o       = PC_PLUS4;
    tmr_en         = 1'b0;
    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        imem_req_o     = 1'b1;
        tmr_en         = 1'b1;
        redirect_ack_o = redir;
        // A redirect overrides a decode stall.
        if_en_o        = imem_ack_i & (~stall_req_i | redir);
        if (redir) pc_sel_o = trap_req_i ? TRAP : JUMP;
        if (tmr_expired) state_d = HALT;
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redir)                              flush_cnt_d = FLUSH_LD;
    else if (if_en_o && flush_cnt_q != 2'd0) flush_cnt_d = flush_cnt_q - 2'd1;
  end

  assign timeout_d       = timeout_q | tmr_expired;
  assign if_flush_o      = (flush_cnt_q != 2'd0);
  assign fetch_timeout_o = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      boot_cnt_q  <= 4'd0;
      flush_cnt_q <= 2'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_redir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_redir_q <= 32'd0;
    end else begin
      if (state_q == RUN && !if_en_o) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_ack_o)             perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o    = perf_stall_q;
  assign perf_redirect_cnt_o = perf_redir_q;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Randomized scoreboard bench for fetch_control against a cycle-level
// reference model of the sequencing rules.
module tb_fetch_control;
  import riscv_definitions::*;

  localparam int BW = 2;
  localparam int MW = 15;
  localparam int FD = 1;

  logic        clk, rst_n;
  logic        imem_req, imem_ack, stall_req, jump_req, trap_req;
  logic        redirect_ack, if_en, if_flush, fetch_timeout;
  nextPCType_e pc_sel;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_redirect_cnt;
`endif

  fetch_control #(.BOOT_WAIT(BW), .MAX_WAIT(MW), .FLUSH_DEPTH(FD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_o      (imem_req),
    .imem_ack_i      (imem_ack),
    .stall_req_i     (stall_req),
    .jump_req_i      (jump_req),
    .trap_req_i      (trap_req),
    .redirect_ack_o  (redirect_ack),
    .if_en_o         (if_en),
    .pc_sel_o        (pc_sel),
    .if_flush_o      (if_flush),
    .fetch_timeout_o (fetch_timeout)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt_o    (perf_stall_cnt),
    .perf_redirect_cnt_o (perf_redirect_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        req, en, rack, flush, tmo;
    logic [1:0]  sel;
    logic [31:0] pst, prd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: plain counters over the rules of fetch sequencing.
  int  m_cyc, m_miss, m_flush;
  bit  m_halt;
  int  m_pst, m_prd;
  bit  jpend, tpend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_miss = 0; m_flush = 0; m_halt = 0;
    m_pst = 0; m_prd = 0; jpend = 0; tpend = 0;
  endtask

  task automatic drive_cycle(input bit in_reset, input bit force_miss);
    exp_t e;
    bit   run, rd;
    @(posedge clk); #1;
    if (in_reset) begin
      rst_n = 1'b0; imem_ack = 1'b0; stall_req = 1'b0;
      jump_req = 1'b0; trap_req = 1'b0;
      model_reset();
      e = '{req:0, en:0, rack:0, flush:0, tmo:0, sel:PC_PLUS4, pst:0, prd:0};
      sb.push_back(e);
      return;
    end
    rst_n     = 1'b1;
    imem_ack  = force_miss ? 1'b0 : ($urandom_range(0, 3) != 0);
    stall_req = ($urandom_range(0, 3) == 0);
    if (!jpend && !tpend && $urandom_range(0, 4) == 0) begin
      case ($urandom_range(0, 2))
        0: jpend = 1;
        1: tpend = 1;
        default: begin jpend = 1; tpend = 1; end
      endcase
    end
    jump_req = jpend;
    trap_req = tpend;

    run = (m_cyc >= BW) && !m_halt;
    rd  = run && imem_ack && (jpend || tpend);
    e.req   = run;
    e.rack  = rd;
    e.en    = run && imem_ack && (!stall_req || rd);
    e.sel   = !rd ? PC_PLUS4 : (tpend ? TRAP : JUMP);
    e.flush = (m_flush > 0);
    e.tmo   = m_halt;
    e.pst   = m_pst;
    e.prd   = m_prd;
    sb.push_back(e);

    if (rd)                         m_flush = FD;
    else if (e.en && m_flush > 0)   m_flush--;
    if (run && !e.en) m_pst++;
    if (rd)           m_prd++;
    if (run) begin
      if (imem_ack) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == MW) m_halt = 1;
      end
    end
    if (m_cyc < BW) m_cyc++;
    // A trap supersedes a pending jump, so both are dropped on any ack.
    if (rd) begin jpend = 0; tpend = 0; end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_req",      32'(imem_req),      32'(e.req));
        chk("if_en",         32'(if_en),         32'(e.en));
        chk("redirect_ack",  32'(redirect_ack),  32'(e.rack));
        chk("pc_sel",        32'(pc_sel),        32'(e.sel));
        chk("if_flush",      32'(if_flush),      32'(e.flush));
        chk("fetch_timeout", 32'(fetch_timeout), 32'(e.tmo));
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_cnt",    perf_stall_cnt,    e.pst);
        chk("perf_redirect_cnt", perf_redirect_cnt, e.prd);
`endif
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; imem_ack = 1'b0; stall_req = 1'b0;
    jump_req = 1'b0; trap_req = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) drive_cycle(1'b1, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      if ((c >= 440 && c < 442) || (c >= 900 && c < 901))
        drive_cycle(1'b1, 1'b0);
      else
        drive_cycle(1'b0, (c >= 400 && c < 425) || (c >= 1200 && c < 1220));
    end
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
